// File: rtl/fibgen_core_if.sv
`default_nettype none
// ============================================================================
// Module      : fibgen_core_if
// Description : Tester-side bundle for the Fibonacci generator.
//               enable   - advance one term per enabled clock (tester -> DUT)
//               monitor  - current term, WIDTH bits          (DUT -> tester)
//               term_cnt - terms since reset/restart, 8 bits (DUT -> tester)
//               wrap     - one-cycle restart pulse           (DUT -> tester)
//               ovf      - sticky overflow flag              (DUT -> tester)
//               Modports: master = tester, slave = generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface fibgen_core_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] monitor;
  logic [7:0]       term_cnt;
  logic             wrap;
  logic             ovf;

  modport master (
    output enable,
    input  monitor,
    input  term_cnt,
    input  wrap,
    input  ovf
  );

  modport slave (
    input  enable,
    output monitor,
    output term_cnt,
    output wrap,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/fibgen_core.sv
`default_nettype none
// ============================================================================
// Module      : fibgen_core
// Description : Fibonacci sequence generator, one term per enabled clock.
//               Halts with a sticky overflow flag when the next term cannot
//               be represented in WIDTH bits. Optional auto-restart above
//               LIMIT is compiled in when FIBGEN_AUTOWRAP_EN is defined.
// Ports       : clock - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - fibgen_core_if.slave (enable in; monitor, term_cnt,
//                       wrap, ovf out; all outputs registered)
// Parameters  : WIDTH - term width (default 8)
//               LIMIT - restart threshold, macro builds only (default 128)
// Macro       : FIBGEN_AUTOWRAP_EN - enables restart-at-LIMIT and wrap pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fibgen_core #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 128
) (
  input  wire logic       clock,
  input  wire logic       reset,
  fibgen_core_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cur,   w_cur_nxt;
  logic [WIDTH:0]   r_nxt,   w_nxt_nxt;
  logic [7:0]       r_cnt,   w_cnt_nxt;
  logic             r_ovf,   w_ovf_nxt;
  logic             r_wrap,  w_wrap_nxt;

  // r_nxt[WIDTH] is clear whenever this sum is used, so it cannot exceed
  // WIDTH+1 bits.
  logic [WIDTH:0]   w_sum;
  assign w_sum = {1'b0, r_cur} + r_nxt;

`ifdef FIBGEN_AUTOWRAP_EN
  localparam logic [WIDTH:0] c_limit = (WIDTH+1)'(LIMIT);
  logic w_restart;
  assign w_restart = (r_state == RUN) && ({1'b0, r_cur} > c_limit);
`else
  // LIMIT only matters for the restart logic; keep it referenced.
  localparam int c_unused_limit = LIMIT;
  logic w_restart;
  assign w_restart = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_nxt_nxt   = r_nxt;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_wrap_nxt  = 1'b0;

    case (r_state)
      IDLE, RUN: begin
        if (bus.enable) begin
          if (w_restart) begin
            // Restart wins over the overflow check.
            w_cur_nxt   = '0;
            w_nxt_nxt   = {{WIDTH{1'b0}}, 1'b1};
            w_cnt_nxt   = 8'd0;
            w_wrap_nxt  = 1'b1;
            w_state_nxt = RUN;
          end else if (r_nxt[WIDTH]) begin
            // Next term is not representable: freeze and flag.
            w_ovf_nxt   = 1'b1;
            w_state_nxt = HALT;
          end else begin
            w_cur_nxt   = r_nxt[WIDTH-1:0];
            w_nxt_nxt   = w_sum;
            w_cnt_nxt   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
            w_state_nxt = RUN;
          end
        end
      end
      default: begin
        // HALT: everything holds until reset.
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_nxt   <= {{WIDTH{1'b0}}, 1'b1};
      r_cnt   <= 8'd0;
      r_ovf   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_nxt   <= w_nxt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.monitor  = r_cur;
  assign bus.term_cnt = r_cnt;
  assign bus.ovf      = r_ovf;
`ifdef FIBGEN_AUTOWRAP_EN
  assign bus.wrap     = r_wrap;
`else
  // wrap can never be set without the restart logic; the tie-off makes the
  // output a constant for the tester.
  logic w_unused_wrap;
  assign w_unused_wrap = r_wrap;
  assign bus.wrap      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fibgen_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibgen_core
// Description : Self-checking bench for fibgen_core (WIDTH=8, LIMIT=128).
//               Vector table plus hand-written overflow/restart sequence and
//               a reactive tester loop that resets when monitor > 128.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibgen_core;

  logic clock;
  logic reset;

  fibgen_core_if #(.WIDTH(8)) bus ();

  fibgen_core #(.WIDTH(8), .LIMIT(128)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] mon;
    logic [7:0] cnt;
    logic       ovf;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] fib [0:13];

  function automatic vec_t mk(input logic rst, input logic en, input int mon,
                              input int cnt, input logic ovf, input logic wrap);
    vec_t v;
    v.rst = rst; v.en = en; v.mon = 8'(mon); v.cnt = 8'(cnt);
    v.ovf = ovf; v.wrap = wrap;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string name, input int idx);
    vec_t e;
    @(negedge clock);
    reset      = v.rst;
    bus.enable = v.en;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.monitor !== e.mon || bus.term_cnt !== e.cnt ||
        bus.ovf !== e.ovf || bus.wrap !== e.wrap) begin
      bad++;
      $display("FAIL %s[%0d]: got mon=%0d cnt=%0d ovf=%0b wrap=%0b, want mon=%0d cnt=%0d ovf=%0b wrap=%0b",
               name, idx, bus.monitor, bus.term_cnt, bus.ovf, bus.wrap,
               e.mon, e.cnt, e.ovf, e.wrap);
    end
  endtask

  initial begin
    int k;
    logic tester_rst;

    fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
            8'd55, 8'd89, 8'd144, 8'd233};
    reset      = 1'b1;
    bus.enable = 1'b0;

    // Reset then 12 enabled steps.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 12; i++) tbl.push_back(mk(0, 1, fib[i], i, 0, 0));
    // Enable pattern 1,0,0,1.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0));
    // Reset together with enable while monitor = 34.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 1, fib[i], i, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0));

    foreach (tbl[i]) apply(tbl[i], "table", i);

    // Run up to 144, then the step past LIMIT / toward overflow.
    apply(mk(1, 0, 0, 0, 0, 0), "seq_reset", 0);
    for (int i = 1; i <= 12; i++) apply(mk(0, 1, fib[i], i, 0, 0), "seq_run", i);
`ifdef FIBGEN_AUTOWRAP_EN
    apply(mk(0, 1, 0, 0, 0, 1), "wrap_restart", 0);
    apply(mk(0, 1, 1, 1, 0, 0), "wrap_after", 0);
    apply(mk(0, 0, 1, 1, 0, 0), "wrap_hold", 0);
`else
    apply(mk(0, 1, 233, 13, 0, 0), "ovf_last_term", 0);
    apply(mk(0, 1, 233, 13, 1, 0), "ovf_rise", 0);
    for (int i = 0; i < 3; i++) apply(mk(0, 1, 233, 13, 1, 0), "halt_enabled", i);
    apply(mk(0, 0, 233, 13, 1, 0), "halt_idle", 0);
    apply(mk(1, 1, 0, 0, 0, 0), "halt_reset", 0);
    apply(mk(0, 1, 1, 1, 0, 0), "halt_resume", 0);
`endif

    // Tester loop: enable held high, reset whenever monitor exceeds 128.
    apply(mk(1, 0, 0, 0, 0, 0), "loop_reset", 0);
    k = 0;
    for (int c = 0; c < 40; c++) begin
      tester_rst = (bus.monitor > 8'd128);
      k = tester_rst ? 0 : k + 1;
      if (k > 13) k = 13;
      apply(mk(tester_rst, 1, fib[k], k, 0, 0), "tester_loop", c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
